// File: rtl/game_logic_n.sv
// Game controller for the stickman runner: select/wait/play/win/lose sequencing,
// world scroll, per-frame coin and pit collision detection, and score keeping.
module game_logic_n #(
    parameter int NUM_COINS      = 3,
    parameter int NUM_LEVELS     = 2,
    parameter int COORD_W        = 10,
    parameter int FRAME_W        = 12,
    parameter int SCORE_W        = 8,
    parameter int STICK_X        = 100,
    parameter int STICK_W        = 20,
    parameter int STICK_H        = 40,
    parameter int COIN_W         = 16,
    parameter int COIN_H         = 16,
    parameter int BASE_SPEED     = 2,
    parameter int LEVEL_LEN      = 3000,
    parameter int WIN_SCORE      = 3,
    parameter int FALL_MARGIN    = 4,
    parameter int COLLIDE_FRAMES = 8
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_clk,
    input  logic [7:0]                   keycode,
    input  logic [COORD_W-1:0]           StickmanTop,
    input  logic [COORD_W-1:0]           GroundY,
    input  logic [NUM_COINS*FRAME_W-1:0] CoinX,
    input  logic [NUM_COINS*COORD_W-1:0] CoinY,
    output logic [4:0]                   status,
    output logic [NUM_LEVELS-1:0]        level_status,
    output logic [FRAME_W-1:0]           frame_counter,
    output logic [NUM_COINS-1:0]         CoinStatus,
    output logic [SCORE_W-1:0]           score,
    output logic                         coin_collide
);

    typedef enum logic [4:0] {
        ST_SELECT = 5'b10000,
        ST_WAIT   = 5'b01000,
        ST_PLAY   = 5'b00100,
        ST_WIN    = 5'b00010,
        ST_LOSE   = 5'b00001
    } state_t;

    localparam int LVL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int HOLD_W    = $clog2(COLLIDE_FRAMES + 1);
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    localparam logic [7:0]         KEY_ENTER = 8'h28;
    localparam logic [7:0]         KEY_LVL0  = 8'h1E;
    localparam logic [FRAME_W:0]   STICK_X_F = (FRAME_W + 1)'(STICK_X);
    localparam logic [FRAME_W:0]   COIN_W_F  = (FRAME_W + 1)'(COIN_W);
    localparam logic [FRAME_W:0]   DX_LIM    = (FRAME_W + 1)'(STICK_W + COIN_W);
    localparam logic [COORD_W:0]   COIN_H_C  = (COORD_W + 1)'(COIN_H);
    localparam logic [COORD_W:0]   DY_LIM    = (COORD_W + 1)'(STICK_H + COIN_H);
    localparam logic [COORD_W:0]   STICK_H_C = (COORD_W + 1)'(STICK_H);
    localparam logic [COORD_W:0]   FALL_C    = (COORD_W + 1)'(FALL_MARGIN);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(COLLIDE_FRAMES);

    function automatic int popcount(input logic [NUM_COINS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_COINS; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    state_t                state_r;
    logic [NUM_LEVELS-1:0] level_status_r;
    logic [LVL_W-1:0]      level_idx_r;
    logic [FRAME_W-1:0]    frame_counter_r;
    logic [NUM_COINS-1:0]  coin_status_r;
    logic [SCORE_W-1:0]    score_r;
    logic                  coin_collide_r;
    logic [HOLD_W-1:0]     hold_r;
    logic                  s1_r, s2_r, s3_r;
    logic [7:0]            key_prev_r;

    logic                  tick_s;
    logic                  key_new_s;
    logic                  enter_s;
    logic [7:0]            key_off_s;
    logic                  lvl_press_s;
    logic [LVL_W-1:0]      lvl_sel_s;
    logic [NUM_COINS-1:0]  hit_s;
    int                    score_sum_s;
    logic [SCORE_W-1:0]    score_nx_s;
    int                    fc_sum_s;
    logic [FRAME_W-1:0]    fc_nx_s;
    logic                  fall_s;
    logic                  level_end_s;
    logic                  win_s;

    assign tick_s      = s2_r & ~s3_r;
    assign key_new_s   = (keycode != key_prev_r);
    assign enter_s     = key_new_s && (keycode == KEY_ENTER);
    // Level keys are a contiguous range; keycodes below it wrap to large offsets.
    assign key_off_s   = keycode - KEY_LVL0;
    assign lvl_press_s = key_new_s && (int'(key_off_s) < NUM_LEVELS);
    assign lvl_sel_s   = LVL_W'(key_off_s);

    genvar g;
    generate
        for (g = 0; g < NUM_COINS; g++) begin : g_coin
            logic [FRAME_W:0] dx_s;
            logic [COORD_W:0] dy_s;
            assign dx_s = {1'b0, CoinX[g*FRAME_W +: FRAME_W]} - {1'b0, frame_counter_r}
                          - STICK_X_F + COIN_W_F;
            assign dy_s = {1'b0, CoinY[g*COORD_W +: COORD_W]} - {1'b0, StickmanTop} + COIN_H_C;
            assign hit_s[g] = ~coin_status_r[g] & (dx_s < DX_LIM) & (dy_s < DY_LIM);
        end
    endgenerate

    assign fall_s      = ({1'b0, StickmanTop} + STICK_H_C) > ({1'b0, GroundY} + FALL_C);
    assign level_end_s = (fc_sum_s >= LEVEL_LEN);
    assign win_s       = (int'(score_nx_s) >= WIN_SCORE);

    // Saturating next score and next scroll position for the current tick
    always_comb begin
        score_sum_s = int'(score_r) + popcount(hit_s);
        if (score_sum_s > SCORE_MAX) begin
            score_nx_s = SCORE_W'(SCORE_MAX);
        end else begin
            score_nx_s = SCORE_W'(score_sum_s);
        end
        fc_sum_s = int'(frame_counter_r) + BASE_SPEED + int'(level_idx_r);
        if (fc_sum_s > LEVEL_LEN) begin
            fc_nx_s = FRAME_W'(LEVEL_LEN);
        end else begin
            fc_nx_s = FRAME_W'(fc_sum_s);
        end
    end

    // Game state machine, frame synchroniser, key history and per-frame bookkeeping
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r         <= ST_SELECT;
            level_status_r  <= '0;
            level_idx_r     <= '0;
            frame_counter_r <= '0;
            coin_status_r   <= '0;
            score_r         <= '0;
            coin_collide_r  <= 1'b0;
            hold_r          <= '0;
            s1_r            <= 1'b0;
            s2_r            <= 1'b0;
            s3_r            <= 1'b0;
            key_prev_r      <= 8'h00;
        end else begin
            s1_r       <= frame_clk;
            s2_r       <= s1_r;
            s3_r       <= s2_r;
            key_prev_r <= keycode;
            if (tick_s && (hold_r != '0)) begin
                hold_r <= hold_r - HOLD_W'(1);
                if (hold_r == HOLD_W'(1)) begin
                    coin_collide_r <= 1'b0;
                end
            end
            case (state_r)
                ST_SELECT: begin
                    if (lvl_press_s) begin
                        level_status_r  <= NUM_LEVELS'(1'b1) << lvl_sel_s;
                        level_idx_r     <= lvl_sel_s;
                        frame_counter_r <= '0;
                        coin_status_r   <= '0;
                        score_r         <= '0;
                        hold_r          <= '0;
                        coin_collide_r  <= 1'b0;
                        state_r         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (enter_s) begin
                        state_r <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick_s) begin
                        coin_status_r   <= coin_status_r | hit_s;
                        score_r         <= score_nx_s;
                        frame_counter_r <= fc_nx_s;
                        if (|hit_s) begin
                            coin_collide_r <= 1'b1;
                            hold_r         <= HOLD_INIT;
                        end
                        // A fall outranks reaching the end of the level.
                        if (fall_s) begin
                            state_r <= ST_LOSE;
                        end else if (level_end_s) begin
                            state_r <= win_s ? ST_WIN : ST_LOSE;
                        end
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (enter_s) begin
                        level_status_r <= '0;
                        level_idx_r    <= '0;
                        score_r        <= '0;
                        coin_status_r  <= '0;
                        state_r        <= ST_SELECT;
                    end
                end
                default: state_r <= ST_SELECT;
            endcase
        end
    end

    assign status        = state_r;
    assign level_status  = level_status_r;
    assign frame_counter = frame_counter_r;
    assign CoinStatus    = coin_status_r;
    assign score         = score_r;
    assign coin_collide  = coin_collide_r;

endmodule

// File: tb/tb_game_logic_n.sv
// Directed bench for game_logic_n: a spec-level game model compared every cycle,
// plus hand-computed expectations at the interesting points of each game.
module tb_game_logic_n;
    localparam int NC = 3;
    localparam int NL = 2;
    localparam int FW = 12;
    localparam int CW = 10;
    localparam int SW = 8;
    localparam int LL = 200;
    localparam int S_SEL = 0, S_WAIT = 1, S_PLAY = 2, S_WIN = 3, S_LOSE = 4;
    localparam int FAR_X = 4000;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             frame_clk;
    logic [7:0]       keycode;
    logic [CW-1:0]    StickmanTop;
    logic [CW-1:0]    GroundY;
    logic [NC*FW-1:0] CoinX;
    logic [NC*CW-1:0] CoinY;
    logic [4:0]       status;
    logic [NL-1:0]    level_status;
    logic [FW-1:0]    frame_counter;
    logic [NC-1:0]    CoinStatus;
    logic [SW-1:0]    score;
    logic             coin_collide;

    game_logic_n #(.LEVEL_LEN(LL)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .StickmanTop(StickmanTop), .GroundY(GroundY), .CoinX(CoinX), .CoinY(CoinY),
        .status(status), .level_status(level_status), .frame_counter(frame_counter),
        .CoinStatus(CoinStatus), .score(score), .coin_collide(coin_collide)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Model state
    int      m_st, m_lvl, m_fc, m_score, m_hold;
    bit [NC-1:0] m_coins;
    bit      m_cc;
    int      cx[NC], cy[NC];
    int      top_i, gnd_i;
    logic [7:0] prev_key;

    function automatic logic [4:0] st_vec(input int s);
        case (s)
            S_SEL:   return 5'b10000;
            S_WAIT:  return 5'b01000;
            S_PLAY:  return 5'b00100;
            S_WIN:   return 5'b00010;
            S_LOSE:  return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [NL-1:0] lvl_vec();
        if (m_lvl < 0) return '0;
        return NL'(1 << m_lvl);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_st = S_SEL; m_lvl = -1; m_fc = 0; m_score = 0; m_hold = 0;
        m_coins = '0; m_cc = 1'b0;
    endtask

    task automatic m_key(input int k);
        case (m_st)
            S_SEL: if (k >= 'h1E && k < 'h1E + NL) begin
                m_lvl = k - 'h1E; m_st = S_WAIT;
                m_fc = 0; m_coins = '0; m_score = 0; m_hold = 0; m_cc = 1'b0;
            end
            S_WAIT: if (k == 'h28) m_st = S_PLAY;
            S_WIN, S_LOSE: if (k == 'h28) begin
                m_st = S_SEL; m_lvl = -1; m_score = 0; m_coins = '0;
            end
            default: ;
        endcase
    endtask

    task automatic m_tick();
        int hits, dx, dy;
        bit [NC-1:0] nc;
        if (m_st == S_PLAY) begin
            hits = 0;
            nc = m_coins;
            for (int i = 0; i < NC; i++) begin
                dx = (cx[i] - m_fc - 100 + 16) % 8192;
                if (dx < 0) dx += 8192;
                dy = (cy[i] - top_i + 16) % 2048;
                if (dy < 0) dy += 2048;
                if (!m_coins[i] && dx < 36 && dy < 56) begin
                    nc[i] = 1'b1;
                    hits++;
                end
            end
            m_coins = nc;
            m_score = (m_score + hits > 255) ? 255 : m_score + hits;
            if (hits > 0) begin
                m_cc = 1'b1; m_hold = 8;
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) m_cc = 1'b0;
            end
            m_fc = (m_fc + 2 + m_lvl > LL) ? LL : m_fc + 2 + m_lvl;
            if (top_i + 40 > gnd_i + 4) m_st = S_LOSE;
            else if (m_fc >= LL) m_st = (m_score >= 3) ? S_WIN : S_LOSE;
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_cc = 1'b0;
        end
    endtask

    // Whole-output comparison against the model on every falling edge
    logic [30:0] act_v, exp_v;
    always @(negedge Clk) begin
        if (chk_en) begin
            act_v = {status, level_status, frame_counter, CoinStatus, score, coin_collide};
            exp_v = {st_vec(m_st), lvl_vec(), FW'(m_fc), m_coins, SW'(m_score), m_cc};
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t: got %h expected %h", $time, act_v, exp_v);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic set_key(input logic [7:0] k);
        keycode = k;
        @(posedge Clk);
        if (k != prev_key) m_key(int'(k));
        prev_key = k;
        #1;
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        m_tick();
        #1;
        wait_cycles(1);
        frame_clk = 1'b0;
        wait_cycles(3);
    endtask

    task automatic do_reset();
        Reset = 1'b1; keycode = 8'h00; prev_key = 8'h00; frame_clk = 1'b0;
        @(posedge Clk);
        m_reset();
        #1;
        Reset = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic set_coin(input int i, input int x, input int y);
        cx[i] = x; cy[i] = y;
        CoinX[i*FW +: FW] = FW'(x);
        CoinY[i*CW +: CW] = CW'(y);
    endtask

    task automatic set_top(input int t);
        top_i = t; StickmanTop = CW'(t);
    endtask

    task automatic start_game(input logic [7:0] lk);
        set_key(lk); set_key(8'h00); set_key(8'h28); set_key(8'h00);
    endtask

    task automatic run_to_end(input int max_ticks, input string nm, input int exp_status);
        for (int i = 0; i < max_ticks && m_st == S_PLAY; i++) tick();
        chk(nm, int'(status), exp_status);
    endtask

    initial begin
        Reset = 1'b1; keycode = 8'h00; frame_clk = 1'b0; prev_key = 8'h00;
        set_top(280); gnd_i = 320; GroundY = 10'd320;
        for (int i = 0; i < NC; i++) set_coin(i, FAR_X, 0);
        m_reset();
        wait_cycles(2);
        do_reset();
        chk("rst_status", int'(status), 'h10);
        chk("rst_fc", int'(frame_counter), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_level", int'(level_status), 0);

        // Game 1: level select, Enter held through a no-coin LOSE
        set_key(8'h20); wait_cycles(2);
        chk("sel_ignore", int'(status), 'h10);
        set_key(8'h1E); wait_cycles(4);
        chk("sel_wait", int'(status), 'h08);
        chk("sel_level", int'(level_status), 'h1);
        set_key(8'h28);
        chk("wait_play", int'(status), 'h04);
        frame_clk = 1'b1;
        repeat (2) @(posedge Clk);
        #1 chk("tick_lat_pre", int'(frame_counter), 0);
        @(posedge Clk);
        m_tick();
        #1 chk("tick_lat_post", int'(frame_counter), 2);
        wait_cycles(1);
        frame_clk = 1'b0;
        wait_cycles(3);
        repeat (9) tick();
        chk("fc_10_ticks", int'(frame_counter), 20);
        run_to_end(120, "lose_noscore", 'h01);
        wait_cycles(5);
        chk("enter_held_lose", int'(status), 'h01);
        set_key(8'h00); set_key(8'h28);
        chk("lose_to_sel", int'(status), 'h10);
        set_key(8'h00);

        // Game 2: single coin hit at frame 32 and the collide hold
        start_game(8'h1E);
        set_coin(0, 150, 300);
        repeat (16) tick();
        chk("coin_pre_fc", int'(frame_counter), 32);
        chk("coin_pre", int'(CoinStatus), 0);
        tick();
        chk("coin_hit", int'(CoinStatus), 'h1);
        chk("coin_score", int'(score), 1);
        chk("coin_cc", int'(coin_collide), 1);
        repeat (7) tick();
        chk("cc_held", int'(coin_collide), 1);
        tick();
        chk("cc_drop", int'(coin_collide), 0);
        repeat (5) tick();
        chk("no_recount", int'(score), 1);
        run_to_end(120, "lose_lowscore", 'h01);
        set_key(8'h28); set_key(8'h00);

        // Game 3: three coins in one tick, then WIN
        start_game(8'h1E);
        for (int i = 0; i < NC; i++) set_coin(i, 150, 300);
        repeat (17) tick();
        chk("three_coins", int'(CoinStatus), 'h7);
        chk("three_score", int'(score), 3);
        run_to_end(120, "win", 'h02);
        set_key(8'h28); set_key(8'h00);
        chk("win_clear_score", int'(score), 0);
        chk("win_clear_coins", int'(CoinStatus), 0);

        // Game 4: level 1 speed, fall on the level-end tick beats a winning score
        set_key(8'h1F);
        chk("lvl1_sel", int'(level_status), 'h2);
        set_key(8'h00); set_key(8'h28); set_key(8'h00);
        tick();
        chk("lvl1_speed", int'(frame_counter), 3);
        for (int i = 0; i < 80 && m_fc < 198; i++) tick();
        chk("lvl1_pre_end", int'(frame_counter), 198);
        chk("lvl1_score", int'(score), 3);
        set_top(290);
        tick();
        chk("fall_end_lose", int'(status), 'h01);
        chk("fall_end_fc", int'(frame_counter), 200);
        set_top(280);
        set_key(8'h28); set_key(8'h00);

        // Game 5: reset mid-play, ticks in SELECT leave the scroll alone
        start_game(8'h1E);
        set_coin(2, FAR_X, 0);
        repeat (17) tick();
        chk("pre_rst_score", int'(score), 2);
        do_reset();
        chk("mid_rst_status", int'(status), 'h10);
        chk("mid_rst_score", int'(score), 0);
        chk("mid_rst_fc", int'(frame_counter), 0);
        repeat (3) tick();
        chk("sel_ticks_fc", int'(frame_counter), 0);

        // Game 6: fall and coin hit on the same tick
        for (int i = 1; i < NC; i++) set_coin(i, FAR_X, 0);
        set_coin(0, 100, 300);
        start_game(8'h1E);
        set_top(290);
        tick();
        chk("fall_lose", int'(status), 'h01);
        chk("fall_coin", int'(CoinStatus), 'h1);
        chk("fall_score", int'(score), 1);
        repeat (8) tick();
        chk("cc_decay_lose", int'(coin_collide), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
